// File: rtl/pulse_50_hz_monitor.sv
// Pulse-train period monitor: measures edge-to-edge intervals,
// flags early and missing pulses, and locks after consecutive good intervals.
module pulse_50_hz_monitor #(
    parameter int NOMINAL_PERIOD   = 65536,
    parameter int TOLERANCE        = 64,
    parameter int LOCK_COUNT       = 4,
    parameter int COUNTER_BIT_SIZE = 17
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        PULSE_IN,
    output logic [COUNTER_BIT_SIZE-1:0] PERIOD,
    output logic                        PERIOD_VALID,
    output logic                        LOCKED,
    output logic                        EARLY,
    output logic                        MISSING
);

    localparam int W  = COUNTER_BIT_SIZE;
    localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [W-1:0]  LO   = W'(NOMINAL_PERIOD - TOLERANCE);
    localparam logic [W-1:0]  HI   = W'(NOMINAL_PERIOD + TOLERANCE);
    localparam logic [GW-1:0] GMAX = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCK    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [GW-1:0] good_q, good_d;
    logic          prev_q;
    logic          rise;

    logic [W-1:0]  period_d;
    logic          valid_d;
    logic          locked_d;
    logic          early_d;
    logic          missing_d;

    assign rise = PULSE_IN & ~prev_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        good_d    = good_q;
        period_d  = PERIOD;
        valid_d   = 1'b0;
        early_d   = 1'b0;
        missing_d = 1'b0;

        unique case (state_q)
            SEARCH: begin
                count_d = '0;
                if (rise) begin
                    state_d = MEASURE;
                    count_d = W'(1);
                    good_d  = '0;
                end
            end
            MEASURE, LOCK: begin
                count_d = count_q + W'(1);
                // An edge on the HI cycle wins over the timeout.
                if (rise) begin
                    count_d = W'(1);
                    if (count_q < LO) begin
                        early_d = 1'b1;
                        good_d  = '0;
                        state_d = MEASURE;
                    end else begin
                        period_d = count_q;
                        valid_d  = 1'b1;
                        if (good_q < GMAX)
                            good_d = good_q + GW'(1);
                        if (good_d >= GMAX)
                            state_d = LOCK;
                    end
                end else if (count_q >= HI) begin
                    missing_d = 1'b1;
                    good_d    = '0;
                    count_d   = '0;
                    state_d   = SEARCH;
                end
            end
            default: begin
                state_d = SEARCH;
                count_d = '0;
                good_d  = '0;
            end
        endcase

        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= SEARCH;
            count_q      <= '0;
            good_q       <= '0;
            prev_q       <= 1'b0;
            PERIOD       <= '0;
            PERIOD_VALID <= 1'b0;
            LOCKED       <= 1'b0;
            EARLY        <= 1'b0;
            MISSING      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            good_q       <= good_d;
            prev_q       <= PULSE_IN;
            PERIOD       <= period_d;
            PERIOD_VALID <= valid_d;
            LOCKED       <= locked_d;
            EARLY        <= early_d;
            MISSING      <= missing_d;
        end
    end

endmodule

// File: tb/tb_pulse_50_hz_monitor.sv
// Bench for pulse_50_hz_monitor at a scaled-down nominal period:
// directed vector table, corner sequences and random trains vs a timestamp model.
module tb_pulse_50_hz_monitor;

    localparam int NOM = 100;
    localparam int TOL = 4;
    localparam int LC  = 4;
    localparam int W   = 8;
    localparam int LO  = NOM - TOL;
    localparam int HI  = NOM + TOL;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         PULSE_IN = 1'b0;
    logic [W-1:0] PERIOD;
    logic         PERIOD_VALID;
    logic         LOCKED;
    logic         EARLY;
    logic         MISSING;

    pulse_50_hz_monitor #(
        .NOMINAL_PERIOD  (NOM),
        .TOLERANCE       (TOL),
        .LOCK_COUNT      (LC),
        .COUNTER_BIT_SIZE(W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PULSE_IN    (PULSE_IN),
        .PERIOD      (PERIOD),
        .PERIOD_VALID(PERIOD_VALID),
        .LOCKED      (LOCKED),
        .EARLY       (EARLY),
        .MISSING     (MISSING)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: timestamps of edges rather than a running counter.
    int m_k;
    int m_t0;
    int m_good;
    int m_period;
    bit m_armed;
    bit m_prev;
    bit m_pv;
    bit m_early;
    bit m_miss;

    typedef struct {
        int gap;
        int pv;
        int early;
        int locked;
        int period;
    } vec_t;

    task automatic model_reset();
        m_k = 0; m_t0 = 0; m_good = 0; m_period = 0;
        m_armed = 0; m_prev = 0; m_pv = 0; m_early = 0; m_miss = 0;
    endtask

    task automatic model_clock(input logic p);
        bit rise;
        int n;
        rise = p && !m_prev;
        m_prev = p;
        m_pv = 0; m_early = 0; m_miss = 0;
        m_k++;
        if (m_armed) begin
            n = m_k - m_t0;
            if (rise) begin
                m_t0 = m_k;
                if (n < LO) begin
                    m_early = 1;
                    m_good = 0;
                end else begin
                    m_period = n;
                    m_pv = 1;
                    if (m_good < LC) m_good++;
                end
            end else if (n >= HI) begin
                m_miss = 1;
                m_armed = 0;
                m_good = 0;
            end
        end else if (rise) begin
            m_armed = 1;
            m_t0 = m_k;
            m_good = 0;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic p);
        int ep;
        @(negedge CLK);
        PULSE_IN = p;
        @(posedge CLK);
        model_clock(p);
        #1;
        ep = m_period;
        checks++;
        if (int'(PERIOD) !== ep || PERIOD_VALID !== m_pv || EARLY !== m_early ||
            MISSING !== m_miss || LOCKED !== (m_good >= LC)) begin
            errors++;
            $display("FAIL model cycle %0d: got period=%0d pv=%b early=%b miss=%b lock=%b, expected period=%0d pv=%b early=%b miss=%b lock=%b",
                     m_k, PERIOD, PERIOD_VALID, EARLY, MISSING, LOCKED,
                     ep, m_pv, m_early, m_miss, (m_good >= LC));
        end
    endtask

    task automatic pulse_after(input int gap);
        repeat (gap - 1) step(1'b0);
        step(1'b1);
    endtask

    task automatic do_reset();
        PULSE_IN = 1'b0;
        RST = 1'b1;
        #1;
        model_reset();
        chk("rst_period", int'(PERIOD), 0);
        chk("rst_valid", int'(PERIOD_VALID), 0);
        chk("rst_locked", int'(LOCKED), 0);
        chk("rst_early", int'(EARLY), 0);
        chk("rst_missing", int'(MISSING), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        vec_t tbl[13];
        int n;
        bit found;

        tbl[0]  = '{5,   0, 0, 0, 0};
        tbl[1]  = '{NOM, 1, 0, 0, NOM};
        tbl[2]  = '{NOM, 1, 0, 0, NOM};
        tbl[3]  = '{NOM, 1, 0, 0, NOM};
        tbl[4]  = '{NOM, 1, 0, 1, NOM};
        tbl[5]  = '{NOM, 1, 0, 1, NOM};
        tbl[6]  = '{HI,  1, 0, 1, HI};
        tbl[7]  = '{LO,  1, 0, 1, LO};
        tbl[8]  = '{LO-1, 0, 1, 0, LO};
        tbl[9]  = '{NOM, 1, 0, 0, NOM};
        tbl[10] = '{NOM, 1, 0, 0, NOM};
        tbl[11] = '{NOM, 1, 0, 0, NOM};
        tbl[12] = '{NOM, 1, 0, 1, NOM};

        #3;
        do_reset();

        foreach (tbl[i]) begin
            pulse_after(tbl[i].gap);
            chk($sformatf("vec%0d_valid", i), int'(PERIOD_VALID), tbl[i].pv);
            chk($sformatf("vec%0d_early", i), int'(EARLY), tbl[i].early);
            chk($sformatf("vec%0d_locked", i), int'(LOCKED), tbl[i].locked);
            chk($sformatf("vec%0d_period", i), int'(PERIOD), tbl[i].period);
            chk($sformatf("vec%0d_missing", i), int'(MISSING), 0);
        end

        // Timeout after a locked train.
        n = 0;
        found = 0;
        while (n < 200 && !found) begin
            step(1'b0);
            n++;
            if (MISSING) found = 1;
        end
        chk("miss_delay", n, HI);
        chk("miss_locked", int'(LOCKED), 0);
        step(1'b0);
        chk("miss_one_cycle", int'(MISSING), 0);
        pulse_after(20);
        chk("search_edge_valid", int'(PERIOD_VALID), 0);

        // Held-high pulse counts once; interval measured from first rising cycle.
        repeat (59) step(1'b1);
        repeat (NOM - 60) step(1'b0);
        step(1'b1);
        chk("held_valid", int'(PERIOD_VALID), 1);
        chk("held_period", int'(PERIOD), NOM);
        chk("held_early", int'(EARLY), 0);

        repeat (3) pulse_after(NOM);
        chk("relock_locked", int'(LOCKED), 1);

        // Asynchronous reset in the middle of a locked interval.
        repeat (30) step(1'b0);
        #2;
        do_reset();
        step(1'b1);
        chk("post_rst_edge_valid", int'(PERIOD_VALID), 0);
        pulse_after(NOM);
        chk("post_rst_valid", int'(PERIOD_VALID), 1);
        chk("post_rst_period", int'(PERIOD), NOM);
        chk("post_rst_locked", int'(LOCKED), 0);

        // Random trains: mostly near nominal, some early and some late.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int g;
            int w;
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 70)
                g = int'($urandom_range(LO - 1, HI + 1));
            else if (sel < 85)
                g = int'($urandom_range(2, LO - 1));
            else
                g = int'($urandom_range(HI, HI + 40));
            w = int'($urandom_range(1, g - 1));
            repeat (w) step(1'b1);
            repeat (g - w) step(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_50_hz_monitor.md
PULSE_50_HZ_MONITOR -- requirements
Module: pulse_50_hz_monitor

Interface
REQ-001 SHALL have parameter NOMINAL_PERIOD, default 65536, meaning expected CLK cycles between pulses (20 ms at 3.2768 MHz).
REQ-002 SHALL have parameter TOLERANCE, default 64, meaning the allowed ± deviation from NOMINAL_PERIOD in cycles.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive in-window intervals required for lock.
REQ-004 SHALL have parameter COUNTER_BIT_SIZE, default 17, meaning the width of the interval counter and PERIOD; it must satisfy NOMINAL_PERIOD+TOLERANCE < 2**COUNTER_BIT_SIZE.
REQ-005 SHALL have port CLK, input, 1, single clock for all logic.
REQ-006 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port PULSE_IN, input, 1, 50 Hz pulse, synchronous to CLK, of any high width.
REQ-008 SHALL have port PERIOD, output, COUNTER_BIT_SIZE, the last accepted interval in CLK cycles.
REQ-009 SHALL have port PERIOD_VALID, output, 1, a one-cycle strobe when PERIOD is updated.
REQ-010 SHALL have port LOCKED, output, 1, high while the pulse train is within tolerance.
REQ-011 SHALL have port EARLY, output, 1, a one-cycle strobe on a too-short interval.
REQ-012 SHALL have port MISSING, output, 1, a one-cycle strobe on timeout with no pulse.

Function
REQ-013 SHALL detect a rising edge as PULSE_IN=1 with the registered previous PULSE_IN=0; a held-high input yields exactly one edge.
REQ-014 SHALL define limits LO=NOMINAL_PERIOD-TOLERANCE and HI=NOMINAL_PERIOD+TOLERANCE.
REQ-015 SHALL implement states SEARCH (await first edge), MEASURE (counting, unlocked) and LOCK (counting, locked).
REQ-016 SHALL load the counter with 1 on any edge that starts an interval and increment it by 1 each cycle thereafter, so that an edge N cycles after the previous edge samples count=N.
REQ-017 SHALL, on an edge in SEARCH, go to MEASURE, load the counter and clear the good-interval count, with no PERIOD_VALID.
REQ-018 SHALL, on an edge in MEASURE/LOCK with LO<=count<=HI, register PERIOD<=count, pulse PERIOD_VALID, saturating-increment the good count and reload the counter.
REQ-019 SHALL enter LOCK and set LOCKED=1 in the same cycle as the PERIOD_VALID that makes the good count reach LOCK_COUNT.
REQ-020 SHALL, on an edge in MEASURE/LOCK with count<LO, pulse EARLY, leave PERIOD unchanged, clear the good count, set LOCKED=0, go to MEASURE and reload the counter.
REQ-021 SHALL, when count==HI in MEASURE/LOCK with no edge that cycle, pulse MISSING on the next cycle, set LOCKED=0, clear the good count, go to SEARCH and hold the counter at 0.
REQ-022 SHALL give an edge in the same cycle as count==HI precedence over timeout and treat it as in-window.
REQ-023 SHALL register all outputs, making them visible the cycle after the CLK edge that samples the pulse edge.
REQ-024 SHALL never assert EARLY, MISSING and PERIOD_VALID in the same cycle.

Reset
REQ-025 SHALL, while RST=1 (asynchronously), force state=SEARCH, counter=0, good count=0, PERIOD=0, PERIOD_VALID=0, LOCKED=0, EARLY=0, MISSING=0 and previous PULSE_IN=0.
REQ-026 SHALL treat PULSE_IN=1 on the first cycle after RST deasserts as a rising edge.
REQ-027 SHALL, when RST is asserted mid-interval, discard the partial count and lock status; after release the monitor needs a fresh first edge plus LOCK_COUNT good intervals to relock.

Verification
REQ-028 SHALL cover: reset, then 6 edges spaced 65536 cycles -> no strobe on edge 1; PERIOD=65536 with PERIOD_VALID on edges 2-6; LOCKED rises with the 4th PERIOD_VALID (edge 5).
REQ-029 SHALL cover: locked train, then intervals of 65600 and 65472 -> both accepted, PERIOD=65600 then 65472, LOCKED stays 1.
REQ-030 SHALL cover: locked train, then interval 65471 -> EARLY one cycle, PERIOD holds 65536, LOCKED=0; the next 4 intervals of 65536 relock.
REQ-031 SHALL cover: locked train, then no edge -> MISSING one cycle after count reaches 65600, LOCKED=0, state SEARCH; the next edge produces no PERIOD_VALID.
REQ-032 SHALL cover: PULSE_IN held high for 1000 cycles at an edge -> a single edge; interval measured from the first rising cycle only.
REQ-033 SHALL cover: RST pulsed at count 30000 while LOCKED -> all outputs 0 immediately (asynchronously); the next edge after release produces no PERIOD_VALID.
